// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/LS memory port arbiter.
package mem_arb_pkg;

  localparam logic [63:0] MEM_BASE_DEFAULT   = 64'h8000_0000;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_LS
  } grant_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } resp_t;

  // Byte address to 64-bit word index; addresses below base wrap silently.
  function automatic logic [63:0] word_idx(input logic [63:0] addr, input logic [63:0] base);
    return (addr - base) >> 3;
  endfunction

endpackage

// File: rtl/mem_arb_resp_buf.sv
// One-deep response holding register with valid/ready handshake.
module mem_arb_resp_buf
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] load_data_i,
  input  logic        resp_ready_i,
  output resp_t       resp_o,
  output logic        free_o
);

  resp_t resp_q, resp_d;

  // A load in the same cycle as a consume overwrites the slot and keeps valid high.
  always_comb begin
    resp_d = resp_q;
    if (load_i) begin
      resp_d.valid = 1'b1;
      resp_d.data  = load_data_i;
    end else if (resp_q.valid && resp_ready_i) begin
      resp_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else begin
      resp_q <= resp_d;
    end
  end

  assign resp_o = resp_q;
  assign free_o = !resp_q.valid || resp_ready_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one 1R/1W memory port between instruction fetch and load/store.
// Optional grant/conflict statistics counters are enabled by MEM_ARB_STATS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [63:0] MEM_BASE   = MEM_BASE_DEFAULT,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [31:0] if_resp_data,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [63:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [63:0] ls_req_wdata,
  input  logic [63:0] ls_req_wmask,
  output logic        ls_resp_valid,
  input  logic        ls_resp_ready,
  output logic [63:0] ls_resp_rdata,
  output logic        mem_en,
  output logic [63:0] mem_idx,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  input  logic [63:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_ls_grants,
  output logic [31:0] stat_conflicts
`endif
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;
  grant_e           gnt;
  logic             if_elig, ls_elig;
  logic             if_free, ls_free;
  resp_t            if_resp, ls_resp;
  logic [63:0]      if_load_data, ls_load_data;
  logic             unused_if_hi;

  // Grant is suppressed while in reset so no access or write escapes.
  always_comb begin
    if_elig = if_req_valid && if_free;
    ls_elig = ls_req_valid && ls_free;
    gnt     = GNT_NONE;
    if (rst_n) begin
      if (ls_elig && (!if_elig || starve_q < CNT_MAX)) begin
        gnt = GNT_LS;
      end else if (if_elig) begin
        gnt = GNT_IF;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_idx   = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    case (gnt)
      GNT_IF: begin
        mem_en  = 1'b1;
        mem_idx = word_idx(if_req_addr, MEM_BASE);
      end
      GNT_LS: begin
        mem_en    = 1'b1;
        mem_idx   = word_idx(ls_req_addr, MEM_BASE);
        mem_wen   = ls_req_wen;
        mem_wdata = ls_req_wdata;
        mem_wmask = ls_req_wmask;
      end
      default: ;
    endcase
  end

  assign if_req_ready = (gnt == GNT_IF);
  assign ls_req_ready = (gnt == GNT_LS);

  assign if_load_data = {32'h0, (if_req_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0])};
  assign ls_load_data = ls_req_wen ? 64'h0 : mem_rdata;

  always_comb begin
    starve_d = starve_q;
    if (gnt == GNT_IF || !if_req_valid) begin
      starve_d = '0;
    end else if (gnt == GNT_LS && starve_q != CNT_MAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  mem_arb_resp_buf u_if_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (gnt == GNT_IF),
    .load_data_i  (if_load_data),
    .resp_ready_i (if_resp_ready),
    .resp_o       (if_resp),
    .free_o       (if_free)
  );

  mem_arb_resp_buf u_ls_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (gnt == GNT_LS),
    .load_data_i  (ls_load_data),
    .resp_ready_i (ls_resp_ready),
    .resp_o       (ls_resp),
    .free_o       (ls_free)
  );

  assign if_resp_valid = if_resp.valid;
  assign if_resp_data  = if_resp.data[31:0];
  assign unused_if_hi  = ^if_resp.data[63:32];
  assign ls_resp_valid = ls_resp.valid;
  assign ls_resp_rdata = ls_resp.data;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_q, stat_ls_q, stat_cf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_q <= '0;
      stat_ls_q <= '0;
      stat_cf_q <= '0;
    end else begin
      if (gnt == GNT_IF && stat_if_q != '1) stat_if_q <= stat_if_q + 32'd1;
      if (gnt == GNT_LS && stat_ls_q != '1) stat_ls_q <= stat_ls_q + 32'd1;
      if (if_elig && ls_elig && stat_cf_q != '1) stat_cf_q <= stat_cf_q + 32'd1;
    end
  end

  assign stat_if_grants = stat_if_q;
  assign stat_ls_grants = stat_ls_q;
  assign stat_conflicts = stat_cf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a 16-word memory model.
module tb_mem_port_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          SMAX = 4;

  logic        clk, rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic [63:0] if_req_addr;
  logic [31:0] if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid, ls_resp_ready;
  logic [63:0] ls_req_addr, ls_req_wdata, ls_req_wmask, ls_resp_rdata;
  logic        mem_en, mem_wen;
  logic [63:0] mem_idx, mem_wdata, mem_wmask, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_if_grants, stat_ls_grants, stat_conflicts;
`endif

  logic [63:0] env_mem [16];
  logic [63:0] ref_mem [16];
  logic        load_en;
  logic [3:0]  load_idx;
  logic [63:0] load_val;

  int          n_tests, n_fail;
  logic [31:0] if_q [$];
  logic [63:0] ls_q [$];
  int          exp_gnt;   // 0 none, 1 IF, 2 LS
  int          starve;

  mem_port_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_ready (if_resp_ready),
    .if_resp_data  (if_resp_data),
    .ls_req_valid  (ls_req_valid),
    .ls_req_ready  (ls_req_ready),
    .ls_req_addr   (ls_req_addr),
    .ls_req_wen    (ls_req_wen),
    .ls_req_wdata  (ls_req_wdata),
    .ls_req_wmask  (ls_req_wmask),
    .ls_resp_valid (ls_resp_valid),
    .ls_resp_ready (ls_resp_ready),
    .ls_resp_rdata (ls_resp_rdata),
    .mem_en        (mem_en),
    .mem_idx       (mem_idx),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rdata     (mem_rdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_if_grants(stat_if_grants),
    .stat_ls_grants(stat_ls_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the DUT actually talks to: combinational read, masked write on posedge.
  assign mem_rdata = env_mem[mem_idx[3:0]];
  always @(posedge clk) begin
    if (load_en) env_mem[load_idx] <= load_val;
    else if (mem_en && mem_wen)
      env_mem[mem_idx[3:0]] <= (env_mem[mem_idx[3:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] widx(input logic [63:0] addr);
    return (addr - BASE) / 8;
  endfunction

  // Expected grant and memory drive, evaluated with inputs stable.
  always @(negedge clk) begin
    logic if_el, ls_el;
    logic [3:0] ri;
    if (!rst_n) begin
      exp_gnt = 0;
      chk("reset_flags", {58'b0, if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, mem_en, mem_wen}, 64'h0);
      chk("reset_data", ls_resp_rdata | {32'h0, if_resp_data} | mem_idx | mem_wdata | mem_wmask, 64'h0);
    end else begin
      if_el = if_req_valid && (if_q.size() == 0 || if_resp_ready);
      ls_el = ls_req_valid && (ls_q.size() == 0 || ls_resp_ready);
      if (ls_el && (!if_el || starve < SMAX)) exp_gnt = 2;
      else if (if_el) exp_gnt = 1;
      else exp_gnt = 0;
      chk("req_ready", {62'b0, if_req_ready, ls_req_ready}, {62'b0, exp_gnt == 1, exp_gnt == 2});
      chk("mem_en_wen", {62'b0, mem_en, mem_wen}, {62'b0, exp_gnt != 0, exp_gnt == 2 && ls_req_wen});
      if (exp_gnt == 1) chk("mem_idx_if", mem_idx, widx(if_req_addr));
      if (exp_gnt == 2) chk("mem_idx_ls", mem_idx, widx(ls_req_addr));
      if (exp_gnt == 2 && ls_req_wen) begin
        chk("mem_wdata", mem_wdata, ls_req_wdata);
        chk("mem_wmask", mem_wmask, ls_req_wmask);
      end
      ri = 4'(widx(ls_req_addr));
      if (ri == 4'hF && exp_gnt == 3) chk("never", 64'h0, 64'h1);
    end
  end

  // Response monitor: pops expected data whenever a response is consumed.
  always @(negedge clk) begin
    logic [31:0] e32;
    logic [63:0] e64;
    if (rst_n) begin
      chk("if_resp_valid", {63'b0, if_resp_valid}, {63'b0, if_q.size() != 0});
      chk("ls_resp_valid", {63'b0, ls_resp_valid}, {63'b0, ls_q.size() != 0});
      if (if_resp_valid && if_resp_ready && if_q.size() != 0) begin
        e32 = if_q.pop_front();
        chk("if_resp_data", {32'h0, if_resp_data}, {32'h0, e32});
      end
      if (ls_resp_valid && ls_resp_ready && ls_q.size() != 0) begin
        e64 = ls_q.pop_front();
        chk("ls_resp_rdata", ls_resp_rdata, e64);
      end
    end
  end

  // Reference model commit at the edge that ends the grant cycle.
  always @(posedge clk) begin
    logic [3:0]  i;
    logic [63:0] w;
    if (!rst_n) begin
      if_q.delete();
      ls_q.delete();
      starve = 0;
    end else begin
      if (exp_gnt == 1) begin
        i = 4'(widx(if_req_addr));
        w = ref_mem[i];
        if_q.push_back(if_req_addr[2] ? w[63:32] : w[31:0]);
      end else if (exp_gnt == 2) begin
        i = 4'(widx(ls_req_addr));
        if (ls_req_wen) begin
          ls_q.push_back(64'h0);
          ref_mem[i] = (ref_mem[i] & ~ls_req_wmask) | (ls_req_wdata & ls_req_wmask);
        end else begin
          ls_q.push_back(ref_mem[i]);
        end
      end
      if (exp_gnt == 1 || !if_req_valid) starve = 0;
      else if (exp_gnt == 2 && starve < SMAX) starve = starve + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_addr(input bit half);
    logic [63:0] a;
    if ($urandom_range(15) == 0) a = BASE - 64'd8;
    else a = BASE + 64'($urandom_range(15)) * 8;
    if (half && $urandom_range(1) == 1) a = a + 64'd4;
    return a;
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_gnt = 0;
    starve  = 0;
    rst_n = 1'b1;
    if_req_valid = 0; if_req_addr = BASE; if_resp_ready = 0;
    ls_req_valid = 0; ls_req_addr = BASE; ls_req_wen = 0;
    ls_req_wdata = 0; ls_req_wmask = 0; ls_resp_ready = 0;
    load_en = 0; load_idx = 0; load_val = 0;
    #2 rst_n = 1'b0;

    for (int k = 0; k < 16; k++) begin
      load_en  = 1'b1;
      load_idx = 4'(k);
      if (k == 0) load_val = 64'h1122_3344_5566_7788;
      else if (k == 2) load_val = 64'h0;
      else load_val = {$urandom, $urandom};
      ref_mem[k] = load_val;
      step();
    end
    load_en = 1'b0;

    // Both requesters valid through reset, then continuously after release.
    if_req_valid = 1; if_req_addr = BASE + 64'h8; if_resp_ready = 1;
    ls_req_valid = 1; ls_req_addr = BASE + 64'h18; ls_req_wen = 0; ls_resp_ready = 1;
    step(); step();
    rst_n = 1'b1;
    repeat (15) step();

    // IF alone, upper instruction half of word 0.
    ls_req_valid = 0;
    if_req_addr  = BASE + 64'h4;
    step();
    if_req_valid = 0;
    step(); step();

    // LS write then read of the same word.
    ls_req_valid = 1; ls_req_addr = BASE + 64'h10; ls_req_wen = 1;
    ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 64'hFFFF_FFFF;
    step();
    ls_req_wen = 0;
    step();
    ls_req_valid = 0;
    step(); step();

    // LS response back-pressure while both request.
    if_req_valid = 1; ls_req_valid = 1; ls_resp_ready = 0;
    repeat (4) step();
    ls_resp_ready = 1;
    step();
    if_req_valid = 0; ls_req_valid = 0;
    step();

    // Reset right after an LS write grant; a pending write request during reset must not land.
    ls_req_valid = 1; ls_req_addr = BASE + 64'h28; ls_req_wen = 1;
    ls_req_wdata = 64'h0123_4567_89AB_CDEF; ls_req_wmask = '1;
    step();
    rst_n = 1'b0;
    ls_req_addr = BASE + 64'h30; ls_req_wdata = 64'hFFFF_0000_FFFF_0000;
    step(); step();
    ls_req_valid = 0;
    rst_n = 1'b1;
    step();
    ls_req_valid = 1; ls_req_wen = 0; ls_req_addr = BASE + 64'h30;
    step();
    ls_req_addr = BASE + 64'h28;
    step();
    ls_req_valid = 0;
    step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if_req_valid  = ($urandom_range(3) != 0);
      if_req_addr   = rand_addr(1'b1);
      if_resp_ready = ($urandom_range(3) != 0);
      ls_req_valid  = ($urandom_range(2) != 0);
      ls_req_addr   = rand_addr(1'b0);
      ls_req_wen    = $urandom_range(1) == 1;
      ls_req_wdata  = {$urandom, $urandom};
      case ($urandom_range(2))
        0: ls_req_wmask = '1;
        1: ls_req_wmask = 64'h0000_0000_FFFF_FFFF;
        default: ls_req_wmask = {$urandom, $urandom};
      endcase
      ls_resp_ready = ($urandom_range(3) != 0);
      step();
    end

    // Drain and confirm every expected response was delivered.
    if_req_valid = 0; ls_req_valid = 0;
    if_resp_ready = 1; ls_resp_ready = 1;
    repeat (4) step();
    chk("drain_if", 64'(if_q.size()), 64'h0);
    chk("drain_ls", 64'(ls_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
